uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO plus bus-master FSM that sits directly upstream of the uart peripheral.
//  CPU/DMA pushes bytes at full rate. The feeder polls UART_STATUS (0x04) and, whenever
//  TX is idle, writes the head byte to UART_TXDATA (0x0C) over the uart register port.
//  Firmware enables UART TX (UART_CTRL bit0) before setting en.
// PARAMETERS
//  DEPTH      16     FIFO entries; power of 2, >=2
//  AW         4      log2(DEPTH)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  en            in   1   1 = drain FIFO into UART; 0 = hold (push still accepted)
//  push_i        in   1   push wr_data_i this cycle
//  wr_data_i     in   8   byte to queue
//  clr_ovf_i     in   1   clear sticky overflow flag
//  full_o        out  1   FIFO full
//  empty_o       out  1   FIFO empty
//  count_o       out  AW+1  entries held, 0..DEPTH
//  ovf_o         out  1   sticky: push attempted while full
//  uart_waddr_o  out  8   uart write address
//  uart_data_o   out  32  uart write data, {24'h0, byte}
//  uart_sel_o    out  4   uart byte select
//  uart_we_o     out  1   uart write strobe, 1-cycle pulse
//  uart_raddr_o  out  8   uart read address
//  uart_rd_o     out  1   uart read strobe, 1-cycle pulse
//  uart_data_i   in   32  uart read data, valid 1 cycle after uart_rd_o
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - FIFO pointers and count 0; ovf_o=0; FSM to IDLE.
//   - All uart_* outputs 0; empty_o=1, full_o=0.
//   - A byte already handed to the uart finishes on the line, and is not tracked.
//  FIFO:
//   - Circular, rd/wr pointers of AW bits, wrap modulo DEPTH; count_o is registered.
//   - push_i & full_o: push dropped, ovf_o<=1. Full blocks push even on a same-cycle pop.
//   - push_i & pop same cycle (not full): count unchanged, both pointers advance.
//   - clr_ovf_i & overflowing push same cycle: ovf_o ends 1 (set wins).
//  FSM, one-hot, registered outputs:
//   - IDLE: if en & !empty_o -> POLL.
//   - POLL: uart_rd_o=1, uart_raddr_o=8'h04 for 1 cycle -> WAIT.
//   - WAIT: sample uart_data_i[0].
//       - If 1 (busy) -> POLL.
//       - If 0 -> WRITE.
//       - If en dropped -> IDLE.
//   - WRITE: 1 cycle with uart_we_o=1, uart_waddr_o=8'h0C, uart_sel_o=4'b0001,
//     uart_data_o={24'h0,head}. FIFO popped on the same edge -> IDLE.
//   - In every state other than WRITE/POLL, strobes are 0; addr/data/sel outputs are 0.
//  Latency:
//   - Push into empty FIFO with en=1: count_o updates next edge.
//   - IDLE->POLL, POLL->WAIT and WAIT->WRITE take 1 cycle each.
//   - First uart write is asserted 4 cycles after push_i.
//   - The uart sets its busy bit on the same edge as the write, so the next poll sees busy.
//  Per byte:
//   - Minimum cost 4 cycles (IDLE, POLL, WAIT, WRITE) when the uart is idle.
//   - Otherwise bytes are spaced by the uart frame time plus <=3 cycles of poll slack.
//  en deasserted mid-WRITE: the write still completes (no partial transaction).
//  Never issues a read and a write in the same cycle; never writes UART_STATUS/CTRL/BAUD.
// TESTING
//  1. Reset, then push 8'h55 with en=1 and uart idle:
//     POLL rd@0x04, then single write 0x0C data 0x55 sel 0x1; count 1->0.
//  2. Push 0x01..0x03 back-to-back, uart busy for 100 cycles after each write:
//     exactly 3 writes, in order, each only after a poll returns bit0=0.
//  3. Push DEPTH+1 bytes with en=0: full_o=1, count_o=DEPTH, ovf_o=1.
//     Then clr_ovf_i -> ovf_o=0; first DEPTH bytes drain intact after en=1.
//  4. Pointer wrap: push/drain 3*DEPTH bytes (0x00..0x2F) in bursts of 5:
//     output sequence identical, no loss.
//  5. Simultaneous push and pop at count=3: count stays 3.
//     Push at full during pop: dropped, ovf_o=1.
//  6. Assert rst while in WAIT with count 4:
//     next cycle all uart_* 0, count_o=0, empty_o=1, no further writes.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus a bus-master FSM that drains the FIFO into the uart
// peripheral. The FSM polls UART_STATUS (0x04). When the TX busy bit reads 0, it writes the
// head byte to UART_TXDATA (0x0C).
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   en              1 = drain FIFO into the uart, 0 = hold (pushes still accepted)
//   push_i          queue wr_data_i this cycle
//   wr_data_i       byte to queue
//   clr_ovf_i       clear sticky overflow flag (a same-cycle overflow wins)
//   full_o          FIFO full
//   empty_o         FIFO empty
//   count_o         entries held, 0..DEPTH
//   ovf_o           sticky flag: push attempted while full
//   uart_waddr_o    uart register write address
//   uart_data_o     uart register write data, {24'h0, byte}
//   uart_sel_o      uart register byte select
//   uart_we_o       uart register write strobe, 1-cycle pulse
//   uart_raddr_o    uart register read address
//   uart_rd_o       uart register read strobe, 1-cycle pulse
//   uart_data_i     uart register read data, valid 1 cycle after uart_rd_o
module uart_tx_feeder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          push_i,
  input  logic [7:0]    wr_data_i,
  input  logic          clr_ovf_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic [7:0]    uart_waddr_o,
  output logic [31:0]   uart_data_o,
  output logic [3:0]    uart_sel_o,
  output logic          uart_we_o,
  output logic [7:0]    uart_raddr_o,
  output logic          uart_rd_o,
  input  logic [31:0]   uart_data_i
);

  localparam logic [7:0] UartStatusAddr = 8'h04;
  localparam logic [7:0] UartTxDataAddr = 8'h0C;

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StPoll  = 4'b0010,
    StWait  = 4'b0100,
    StWrite = 4'b1000
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;
  logic          push_ok, pop;

  // Only the busy bit of UART_STATUS is of interest.
  logic unused_rdata;
  assign unused_rdata = ^uart_data_i[31:1];

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

  // Full blocks a push even when the same cycle pops.
  assign push_ok = push_i & ~full_o;
  // WRITE is only ever entered with a non-empty FIFO, so the pop is always valid.
  assign pop     = (state_q == StWrite);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      // Set has priority over clear.
      if (push_i && full_o) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en && !empty_o) state_d = StPoll;
      StPoll:  state_d = StWait;
      StWait: begin
        if (!en) begin
          state_d = StIdle;
        end else if (uart_data_i[0]) begin
          state_d = StPoll;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are registered from the next state, so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      uart_rd_o    <= 1'b0;
      uart_raddr_o <= '0;
      uart_we_o    <= 1'b0;
      uart_waddr_o <= '0;
      uart_data_o  <= '0;
      uart_sel_o   <= '0;
    end else begin
      state_q      <= state_d;
      uart_rd_o    <= (state_d == StPoll);
      uart_raddr_o <= (state_d == StPoll) ? UartStatusAddr : 8'h00;
      uart_we_o    <= (state_d == StWrite);
      uart_waddr_o <= (state_d == StWrite) ? UartTxDataAddr : 8'h00;
      uart_data_o  <= (state_d == StWrite) ? {24'h0, mem_q[rd_ptr_q]} : 32'h0;
      uart_sel_o   <= (state_d == StWrite) ? 4'b0001 : 4'b0000;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic          push_i;
  logic [7:0]    wr_data_i;
  logic          clr_ovf_i;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          ovf_o;
  logic [7:0]    uart_waddr_o;
  logic [31:0]   uart_data_o;
  logic [3:0]    uart_sel_o;
  logic          uart_we_o;
  logic [7:0]    uart_raddr_o;
  logic          uart_rd_o;
  logic [31:0]   uart_data_i;

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .push_i       (push_i),
    .wr_data_i    (wr_data_i),
    .clr_ovf_i    (clr_ovf_i),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .count_o      (count_o),
    .ovf_o        (ovf_o),
    .uart_waddr_o (uart_waddr_o),
    .uart_data_o  (uart_data_o),
    .uart_sel_o   (uart_sel_o),
    .uart_we_o    (uart_we_o),
    .uart_raddr_o (uart_raddr_o),
    .uart_rd_o    (uart_rd_o),
    .uart_data_i  (uart_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Uart model: busy for busy_len cycles after each TXDATA write; hold_busy forces busy.
  int busy_cnt  = 0;
  int busy_len  = 0;
  bit hold_busy = 1'b0;
  logic uart_busy;
  assign uart_busy   = (busy_cnt != 0) || hold_busy;
  assign uart_data_i = {31'b0, uart_busy};

  always @(posedge clk) begin
    if (uart_we_o) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Reference model: a byte queue bounded at DEPTH, plus a sticky overflow flag.
  byte unsigned exp_q[$];
  int occ       = 0;
  bit model_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      occ       <= 0;
      model_ovf <= 1'b0;
      exp_q.delete();
    end else begin
      if (push_i && occ < DEPTH) exp_q.push_back(wr_data_i);
      occ <= occ + ((push_i && occ < DEPTH) ? 1 : 0) - (uart_we_o ? 1 : 0);
      if (push_i && occ >= DEPTH) model_ovf <= 1'b1;
      else if (clr_ovf_i)         model_ovf <= 1'b0;
    end
  end

  // Monitor: checks status every cycle and pops the scoreboard on each uart write.
  always @(negedge clk) begin
    chk("count", count_o, occ);
    chk("empty", empty_o, occ == 0);
    chk("full", full_o, occ == DEPTH);
    chk("ovf", ovf_o, model_ovf);
    if (uart_we_o) begin
      writes <= writes + 1;
      chk("wr_rd_exclusive", uart_rd_o, 1'b0);
      chk("waddr", uart_waddr_o, 8'h0C);
      chk("sel", uart_sel_o, 4'h1);
      chk("write_while_uart_busy", uart_busy, 1'b0);
      chk("write_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("wdata", uart_data_o, {24'h0, exp_q.pop_front()});
    end else begin
      chk("write_fields_zero", {uart_waddr_o, uart_data_o, uart_sel_o}, 44'h0);
    end
    if (uart_rd_o) chk("raddr", uart_raddr_o, 8'h04);
    else           chk("raddr_zero", uart_raddr_o, 8'h00);
  end

  // Called on a negedge; returns on the following negedge.
  task automatic push_byte(input logic [7:0] b);
    push_i    = 1'b1;
    wr_data_i = b;
    @(negedge clk);
    push_i    = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (occ != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < budget, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_write(input int budget);
    int n;
    n = 0;
    while (!uart_we_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("write_seen_in_time", uart_we_o, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rd_at, w0, n;
    rst = 1'b1; en = 1'b0; push_i = 1'b0; wr_data_i = 8'h00; clr_ovf_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_strobes", {uart_we_o, uart_rd_o}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, idle uart; poll two cycles and write four cycles after the push.
    en = 1'b1; busy_len = 0;
    push_byte(8'h55);
    lat = 1; rd_at = 0;
    while (!uart_we_o && lat < 20) begin
      @(negedge clk);
      lat++;
      if (uart_rd_o && rd_at == 0) rd_at = lat;
    end
    chk("t1_write_latency", lat, 4);
    chk("t1_poll_latency", rd_at, 2);
    chk("t1_wdata", uart_data_o, 32'h55);
    wait_drain(100);
    chk("t1_count_after", count_o, 0);

    // 2: three bytes, uart busy 100 cycles after each write.
    busy_len = 100; w0 = writes;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    wait_drain(1000);
    chk("t2_writes", writes - w0, 3);

    // 3: overflow with en=0, clear, then drain the first DEPTH bytes.
    en = 1'b0; busy_len = $urandom_range(0, 8);
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
    chk("t3_full", full_o, 1'b1);
    chk("t3_count", count_o, DEPTH);
    chk("t3_ovf", ovf_o, 1'b1);
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    chk("t3_ovf_cleared", ovf_o, 1'b0);
    w0 = writes; en = 1'b1;
    wait_drain(3000);
    chk("t3_writes", writes - w0, DEPTH);

    // 4: pointer wrap, 0x00..0x2F in bursts of 5.
    w0 = writes;
    for (int b = 0; b < 3 * DEPTH; b += 5) begin
      busy_len = $urandom_range(0, 6);
      for (int i = b; i < b + 5 && i < 3 * DEPTH; i++) push_byte(8'(i));
      wait_drain(500);
    end
    chk("t4_writes", writes - w0, 3 * DEPTH);

    // 5a: push in the same cycle as a pop at count 3.
    en = 1'b0; busy_len = 0;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    en = 1'b1;
    wait_write(200);
    chk("t5_count_at_pop", count_o, 3);
    push_byte(8'hA5);
    chk("t5_count_stays", count_o, 3);
    wait_drain(200);

    // 5b: push at full during a pop is dropped and flags overflow.
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    chk("t5_full", full_o, 1'b1);
    hold_busy = 1'b0;
    wait_write(200);
    chk("t5_count_full_at_pop", count_o, DEPTH);
    push_byte(8'h5A);
    chk("t5_count_after_drop", count_o, DEPTH - 1);
    chk("t5_ovf", ovf_o, 1'b1);
    wait_drain(500);
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;

    // 6: reset while waiting on a busy uart with 4 bytes queued.
    en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    hold_busy = 1'b1; en = 1'b1;
    n = 0;
    while (!uart_rd_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_poll_seen", uart_rd_o, 1'b1);
    @(negedge clk);
    chk("t6_count_in_wait", count_o, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; hold_busy = 1'b0;
    chk("t6_uart_zero", {uart_waddr_o, uart_data_o, uart_sel_o, uart_we_o, uart_raddr_o,
                         uart_rd_o}, 54'h0);
    chk("t6_count", count_o, 0);
    chk("t6_empty", empty_o, 1'b1);
    w0 = writes;
    repeat (30) @(negedge clk);
    chk("t6_no_writes", writes - w0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
